// File: rtl/io_intr_ctrl.sv
// Port and interrupt controller at the write-back boundary: I/O port registers, edge-detected
// interrupt sources with mask, fixed-priority locked request handshake, and halt/wake control.
module io_intr_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IDW = $clog2(NUM_IRQ),
  parameter logic [NUM_IRQ-1:0] MASK_RESET = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_port,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               out_en,
  input  logic [DATA_W-1:0]  data_from_cpu,
  input  logic               HLT_en,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               intr_clear,
  output logic [DATA_W-1:0]  out_port,
  output logic [DATA_W-1:0]  data_to_cpu,
  output logic               intr_flag,
  output logic [IDW-1:0]     intr_id,
  output logic               HLT_flag,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [0:0] {StIdle, StReq} state_t;

  state_t               state_q;
  logic [NUM_IRQ-1:0]   s1_q, s2_q, edge_q, mask_q;
  logic [NUM_IRQ-1:0]   rise, clr, req, pending_d;
  logic [IDW-1:0]       sel_id;

  always_comb begin
    rise   = s2_q & ~edge_q;
    req    = pending & mask_q;
    sel_id = '0;
    // Scan downwards so the lowest set index wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel_id = IDW'(i);
    end
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = intr_clear && (state_q == StReq) && (intr_id == IDW'(i));
    end
    // A new rise wins over a simultaneous clear on the same bit.
    pending_d = rise | (pending & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      edge_q  <= '0;
      pending <= '0;
      mask_q  <= MASK_RESET;
    end else begin
      s1_q    <= irq;
      s2_q    <= s1_q;
      edge_q  <= s2_q;
      pending <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      intr_flag <= 1'b0;
      intr_id   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q   <= StReq;
            intr_flag <= 1'b1;
            intr_id   <= sel_id;
          end
        end
        StReq: begin
          if (intr_clear) begin
            state_q   <= StIdle;
            intr_flag <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          intr_flag <= 1'b0;
        end
      endcase
    end
  end

  // An outstanding request wakes the processor and overrides a halt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      HLT_flag <= 1'b0;
    end else begin
      HLT_flag <= (HLT_flag | HLT_en) & ~(state_q == StReq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_port    <= '0;
      data_to_cpu <= '0;
    end else begin
      if (out_en) out_port <= data_from_cpu;
      data_to_cpu <= in_port;
    end
  end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed bench for io_intr_ctrl: reset, priority/lock, masking, rise-vs-clear, halt/wake, ports.
module tb_io_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_port, data_from_cpu, out_port, data_to_cpu;
  logic [3:0] irq, mask_wdata, pending;
  logic       out_en, HLT_en, mask_we, intr_clear, intr_flag, HLT_flag;
  logic [1:0] intr_id;

  int n_cmp = 0;
  int n_err = 0;

  io_intr_ctrl #(.DATA_W(8), .NUM_IRQ(4)) dut (
    .clk(clk), .rst(rst), .in_port(in_port), .irq(irq), .out_en(out_en),
    .data_from_cpu(data_from_cpu), .HLT_en(HLT_en), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .intr_clear(intr_clear), .out_port(out_port),
    .data_to_cpu(data_to_cpu), .intr_flag(intr_flag), .intr_id(intr_id),
    .HLT_flag(HLT_flag), .pending(pending)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    intr_clear = 1'b1;
    step(1);
    intr_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_port = '0; data_from_cpu = '0; irq = '0; out_en = 1'b0;
    HLT_en = 1'b0; mask_we = 1'b0; mask_wdata = '0; intr_clear = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_out_port", 32'(out_port), 32'h0);
    chk("rst_data_to_cpu", 32'(data_to_cpu), 32'h0);
    chk("rst_flag", 32'(intr_flag), 32'h0);
    chk("rst_id", 32'(intr_id), 32'h0);
    chk("rst_hlt", 32'(HLT_flag), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);

    // Default mask enables irq[3]; flag appears exactly 4 edges after the rise.
    irq = 4'b1000;
    step(3);
    chk("irq3_pending_e3", 32'(pending), 32'h8);
    chk("irq3_flag_e3", 32'(intr_flag), 32'h0);
    step(1);
    chk("irq3_flag_e4", 32'(intr_flag), 32'h1);
    chk("irq3_id", 32'(intr_id), 32'h3);
    ack();
    chk("irq3_clr_flag", 32'(intr_flag), 32'h0);
    chk("irq3_clr_pending", 32'(pending), 32'h0);
    irq = '0;
    step(3);

    // Priority and lock
    irq = 4'b0110;
    step(4);
    chk("pri_flag", 32'(intr_flag), 32'h1);
    chk("pri_id", 32'(intr_id), 32'h1);
    irq = 4'b0111;
    step(4);
    chk("lock_id", 32'(intr_id), 32'h1);
    chk("lock_pending", 32'(pending), 32'h7);
    ack();
    chk("lock_clr_flag", 32'(intr_flag), 32'h0);
    chk("lock_clr_pending", 32'(pending), 32'h5);
    step(1);
    chk("next_flag", 32'(intr_flag), 32'h1);
    chk("next_id0", 32'(intr_id), 32'h0);
    ack();
    chk("gap_flag", 32'(intr_flag), 32'h0);
    chk("gap_pending", 32'(pending), 32'h4);
    step(1);
    chk("next_id2", 32'(intr_id), 32'h2);
    ack();
    chk("all_clr_pending", 32'(pending), 32'h0);
    irq = '0;
    step(3);

    // Masking
    mask_we = 1'b1; mask_wdata = 4'b1110;
    step(1);
    mask_we = 1'b0;
    irq = 4'b0001;
    step(3);
    chk("mask_pending", 32'(pending), 32'h1);
    step(20);
    chk("mask_flag_held", 32'(intr_flag), 32'h0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    step(1);
    mask_we = 1'b0;
    chk("unmask_flag_e0", 32'(intr_flag), 32'h0);
    step(1);
    chk("unmask_flag", 32'(intr_flag), 32'h1);
    chk("unmask_id", 32'(intr_id), 32'h0);
    ack();
    irq = '0;
    step(3);
    chk("unmask_done_pending", 32'(pending), 32'h0);

    // Rise of irq[2] lands on the same edge as the clear
    irq = 4'b0100;
    step(4);
    chk("rc_id", 32'(intr_id), 32'h2);
    irq = '0;
    step(3);
    irq = 4'b0100;
    step(2);
    ack();
    chk("rc_pending_kept", 32'(pending), 32'h4);
    chk("rc_flag_gap", 32'(intr_flag), 32'h0);
    step(1);
    chk("rc_flag_again", 32'(intr_flag), 32'h1);
    chk("rc_id_again", 32'(intr_id), 32'h2);
    ack();
    chk("rc_pending_clr", 32'(pending), 32'h0);
    irq = '0;
    step(3);

    // Halt and wake
    HLT_en = 1'b1;
    step(1);
    HLT_en = 1'b0;
    chk("hlt_set", 32'(HLT_flag), 32'h1);
    step(2);
    chk("hlt_held", 32'(HLT_flag), 32'h1);
    irq = 4'b0010;
    step(4);
    chk("wake_flag_e4", 32'(intr_flag), 32'h1);
    chk("wake_hlt_e4", 32'(HLT_flag), 32'h1);
    step(1);
    chk("wake_hlt_e5", 32'(HLT_flag), 32'h0);
    HLT_en = 1'b1;
    step(1);
    HLT_en = 1'b0;
    chk("hlt_in_req", 32'(HLT_flag), 32'h0);
    ack();
    irq = '0;
    step(3);

    // Ports
    out_en = 1'b1; data_from_cpu = 8'hA5;
    step(1);
    out_en = 1'b0; data_from_cpu = 8'hFF;
    chk("out_port_load", 32'(out_port), 32'hA5);
    step(2);
    chk("out_port_hold", 32'(out_port), 32'hA5);
    in_port = 8'h3C;
    step(1);
    chk("data_to_cpu", 32'(data_to_cpu), 32'h3C);

    // Reset while a request is outstanding
    irq = 4'b1001;
    step(4);
    chk("pre_rst_flag", 32'(intr_flag), 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_flag", 32'(intr_flag), 32'h0);
    chk("mid_rst_pending", 32'(pending), 32'h0);
    chk("mid_rst_out_port", 32'(out_port), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_intr_ctrl.md
# io_intr_ctrl

Parametrised port and interrupt controller for the pipelined processor, sitting at the write-back boundary. It has a DATA_W-wide input and output port, NUM_IRQ edge-triggered interrupt sources, a software mask register, fixed priority arbitration with a locked vector handshake, and halt/wake control. Interrupt requests go to the control unit as a flag plus a source index. The control unit acknowledges each request with a one-cycle clear.

## Interface
- DATA_W, 8, width of ports and CPU data paths
- NUM_IRQ, 4, number of interrupt sources (≥2)
- IDW, $clog2(NUM_IRQ), width of intr_id
- MASK_RESET, all ones, reset value of mask register (1 = enabled)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_port  in  DATA_W  external input port
- irq  in  NUM_IRQ  asynchronous interrupt lines; rising edge = event
- out_en  in  1  load out_port from data_from_cpu (write-back stage)
- data_from_cpu  in  DATA_W  write-back data
- HLT_en  in  1  halt request from write-back stage
- mask_we  in  1  write mask register
- mask_wdata  in  NUM_IRQ  new mask value
- intr_clear  in  1  control-unit acknowledge of the current request
- out_port  out  DATA_W  registered output port
- data_to_cpu  out  DATA_W  in_port registered once
- intr_flag  out  1  request outstanding (state REQ)
- intr_id  out  IDW  source index of outstanding request, locked while intr_flag=1
- HLT_flag  out  1  processor halted
- pending  out  NUM_IRQ  pending-event register (debug/readback)

## Operation
- Reset: out_port=0, data_to_cpu=0, intr_flag=0, intr_id=0, HLT_flag=0, pending=0, mask=MASK_RESET, synchronizer/edge flops=0, state=IDLE. Reset mid-request drops the request and all pending events.
- Sync: irq→s1→s2. Edge register d<=s2. rise = s2 & ~d.
- pending[i] next = rise[i] | (pending[i] & ~clr[i]). clr[i] = intr_clear & state==REQ & intr_id==i. A rise and a clear on the same bit in the same cycle leave the bit set (new event kept).
- Masked sources still set pending. They are not arbitrated until unmasked. A mask write takes effect next cycle.
- FSM IDLE: when req = pending & mask is non-zero, latch intr_id = lowest set index (index 0 is highest priority) and go to REQ.
- FSM REQ: intr_flag=1 and intr_id is frozen. Higher-priority arrivals and mask changes do not alter it. On intr_clear, clear pending[intr_id] and go to IDLE. intr_clear in IDLE is ignored.
- HLT_flag next = (HLT_flag | HLT_en) & ~(state==REQ). An outstanding request wakes the processor. HLT_en while in REQ has no effect.
- out_port <= data_from_cpu when out_en; otherwise hold. data_to_cpu <= in_port every cycle.

## Timing
- irq rise stable before edge E1: s2=1 after E2, pending set at E3, intr_flag=1 and intr_id valid after E4. Event-to-flag latency is 4 cycles.
- irq pulses shorter than one clock are not guaranteed to be captured. Level-high irq produces one event only.
- intr_clear sampled at edge Ec: intr_flag=0 after Ec. If other unmasked bits are pending, the next REQ starts after Ec+1. The gap between requests is at least one cycle.
- Wake: HLT_flag falls on the edge after the request enters REQ, i.e. after E5 from the irq rise.
- out_port changes one cycle after out_en. data_to_cpu lags in_port by one cycle.

## Test plan
- Reset then idle: after rst=1 for 2 cycles, all outputs 0 and pending=0. Read mask back via behaviour: raise irq[3] → intr_flag=1, intr_id=3 exactly 4 cycles later.
- Priority and lock: raise irq[2] and irq[1] together → intr_id=1. Raise irq[0] while in REQ → intr_id stays 1. intr_clear → pending=4'b0101, one IDLE cycle, then intr_id=0, then 2 after clears.
- Masking: write mask=4'b1110, raise irq[0] → pending[0]=1, intr_flag stays 0 for 20 cycles. Write mask=4'b1111 → intr_flag=1, intr_id=0 on the next cycle.
- Simultaneous rise and clear: in REQ with id=2, drop then re-raise irq[2] so its rise coincides with intr_clear → pending[2] remains 1 and a new REQ id=2 follows.
- Halt/wake: pulse HLT_en → HLT_flag=1 and held. Raise irq[1] → HLT_flag=0 at E5. HLT_en during REQ → HLT_flag stays 0.
- Ports and reset mid-op: out_en with data 8'hA5 → out_port=8'hA5 next cycle, held when out_en=0. in_port=8'h3C → data_to_cpu=8'h3C one cycle later. Assert rst in REQ → intr_flag=0 and pending=0 next cycle.
